// File: rtl/core_pkg.sv
// Shared constants for the multi-port register file and its scoreboard.
package core_pkg;

  // Default data width and architectural register count.
  localparam int XLEN_DEF  = 64;
  localparam int NREGS_DEF = 32;

  // Hard-wired zero register: it always reads 0, is never pending, and
  // ignores writes and issue claims.
  localparam int REG_ZERO = 0;

  // Write-port priority: when several enabled write ports target the same
  // register in one cycle, the highest-indexed port wins. The same ordering
  // selects the bypass source when bypass is built in.

endpackage

// File: rtl/regfile_sb_pending.sv
// Scoreboard for regfile_mp_sb: one pending bit per non-zero register.
// A writeback clears a bit, an accepted issue claim sets it, and when both
// hit the same register in one cycle the claim wins.
module regfile_sb_pending
  import core_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int NWP   = 2,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NWP-1:0]   w_en,
  input  logic [NWP*AW-1:0] w_addr,
  input  logic             issue_valid,
  input  logic [AW-1:0]    issue_rd,
  output logic             issue_ready,
  output logic             any_pending,
  output logic [NREGS-1:1] pending
);

  logic [NREGS-1:1] pending_next;
  logic             rd_pending;

  // Look up the pending bit of the register the issuer wants to claim;
  // the zero register and out-of-range addresses are never pending.
  always_comb begin
    rd_pending = 1'b0;
    for (int r = REG_ZERO + 1; r < NREGS; r++) begin
      if (issue_rd == AW'(r)) rd_pending = pending[r];
    end
  end

  assign issue_ready = !rd_pending;
  assign any_pending = |pending;

  // Next pending vector: clears from every write port first, then the
  // issue claim, so a same-cycle claim overrides the clear.
  always_comb begin
    pending_next = pending;
    for (int wp = 0; wp < NWP; wp++) begin
      for (int r = REG_ZERO + 1; r < NREGS; r++) begin
        if (w_en[wp] && (w_addr[wp*AW +: AW] == AW'(r))) pending_next[r] = 1'b0;
      end
    end
    for (int r = REG_ZERO + 1; r < NREGS; r++) begin
      if (issue_valid && issue_ready && (issue_rd == AW'(r))) pending_next[r] = 1'b1;
    end
  end

  // Pending state register; reset drops all outstanding producers.
  always_ff @(posedge clk) begin
    if (reset) pending <= '0;
    else       pending <= pending_next;
  end

endmodule

// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb: parametrised NRP-read / NWP-write register file with an
// integrated pending-bit scoreboard.
// Optional build macro REGFILE_BYPASS_EN: a read that matches an enabled
// write port in the same cycle returns that port's W_DATA and reports
// not-pending. Without it reads see stored state only.
//
// Issue handshake: a destination is claimed on a rising CLK edge where
// ISSUE_VALID && ISSUE_READY. ISSUE_READY does not depend on ISSUE_VALID;
// while it is low the issuer holds ISSUE_RD and retries.
module regfile_mp_sb
  import core_pkg::*;
#(
  parameter  int XLEN  = XLEN_DEF,
  parameter  int NREGS = NREGS_DEF,
  parameter  int NRP   = 2,
  parameter  int NWP   = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [NRP*AW-1:0]   R_ADDR,
  output logic [NRP*XLEN-1:0] R_DATA,
  output logic [NRP-1:0]      R_PENDING,
  input  logic [NWP-1:0]      W_EN,
  input  logic [NWP*AW-1:0]   W_ADDR,
  input  logic [NWP*XLEN-1:0] W_DATA,
  input  logic                ISSUE_VALID,
  input  logic [AW-1:0]       ISSUE_RD,
  output logic                ISSUE_READY,
  output logic                ANY_PENDING
);

  // Register 0 has no storage; it is synthesised as constant zero.
  logic [XLEN-1:0]  regs [1:NREGS-1];
  logic [NREGS-1:1] pending;

  regfile_sb_pending #(
    .NREGS (NREGS),
    .NWP   (NWP),
    .AW    (AW)
  ) u_pending (
    .clk         (CLK),
    .reset       (RESET),
    .w_en        (W_EN),
    .w_addr      (W_ADDR),
    .issue_valid (ISSUE_VALID),
    .issue_rd    (ISSUE_RD),
    .issue_ready (ISSUE_READY),
    .any_pending (ANY_PENDING),
    .pending     (pending)
  );

  // Data array: reset to zero, otherwise apply write ports in ascending
  // order so the last (highest-indexed) matching port lands.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int r = REG_ZERO + 1; r < NREGS; r++) regs[r] <= '0;
    end else begin
      for (int wp = 0; wp < NWP; wp++) begin
        for (int r = REG_ZERO + 1; r < NREGS; r++) begin
          if (W_EN[wp] && (W_ADDR[wp*AW +: AW] == AW'(r)))
            regs[r] <= W_DATA[wp*XLEN +: XLEN];
        end
      end
    end
  end

  // Combinational read ports; unmatched addresses (zero register or out of
  // range) fall through to 0 / not-pending.
  always_comb begin
    R_DATA    = '0;
    R_PENDING = '0;
    for (int p = 0; p < NRP; p++) begin
      for (int r = REG_ZERO + 1; r < NREGS; r++) begin
        if (R_ADDR[p*AW +: AW] == AW'(r)) begin
          R_DATA[p*XLEN +: XLEN] = regs[r];
          R_PENDING[p]           = pending[r];
        end
      end
`ifdef REGFILE_BYPASS_EN
      for (int wp = 0; wp < NWP; wp++) begin
        for (int r = REG_ZERO + 1; r < NREGS; r++) begin
          if (W_EN[wp] && (W_ADDR[wp*AW +: AW] == AW'(r)) &&
              (R_ADDR[p*AW +: AW] == AW'(r))) begin
            R_DATA[p*XLEN +: XLEN] = W_DATA[wp*XLEN +: XLEN];
            R_PENDING[p]           = 1'b0;
          end
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Testbench for regfile_mp_sb: a default-configured instance checked every
// cycle against an array/bit-vector model, plus a 24-register, 32-bit,
// 3-read / 1-write instance checked with directed expectations.
module tb_regfile_mp_sb;

  localparam int XLEN = 64, NREGS = 32, NRP = 2, NWP = 2, AW = 5;
  localparam int PX = 32, PN = 24, PRP = 3, PWP = 1, PAW = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // ---------------- default instance ----------------
  logic [NRP*AW-1:0]   r_addr;
  logic [NRP*XLEN-1:0] r_data;
  logic [NRP-1:0]      r_pending;
  logic [NWP-1:0]      w_en;
  logic [NWP*AW-1:0]   w_addr;
  logic [NWP*XLEN-1:0] w_data;
  logic                issue_valid;
  logic [AW-1:0]       issue_rd;
  logic                issue_ready;
  logic                any_pending;

  regfile_mp_sb u_dut (
    .CLK (clk), .RESET (reset),
    .R_ADDR (r_addr), .R_DATA (r_data), .R_PENDING (r_pending),
    .W_EN (w_en), .W_ADDR (w_addr), .W_DATA (w_data),
    .ISSUE_VALID (issue_valid), .ISSUE_RD (issue_rd),
    .ISSUE_READY (issue_ready), .ANY_PENDING (any_pending)
  );

  // ---------------- reduced instance ----------------
  logic [PRP*PAW-1:0] p_r_addr;
  logic [PRP*PX-1:0]  p_r_data;
  logic [PRP-1:0]     p_r_pending;
  logic [PWP-1:0]     p_w_en;
  logic [PWP*PAW-1:0] p_w_addr;
  logic [PWP*PX-1:0]  p_w_data;
  logic               p_issue_valid;
  logic [PAW-1:0]     p_issue_rd;
  logic               p_issue_ready;
  logic               p_any_pending;

  regfile_mp_sb #(.XLEN(PX), .NREGS(PN), .NRP(PRP), .NWP(PWP)) u_dut_p (
    .CLK (clk), .RESET (reset),
    .R_ADDR (p_r_addr), .R_DATA (p_r_data), .R_PENDING (p_r_pending),
    .W_EN (p_w_en), .W_ADDR (p_w_addr), .W_DATA (p_w_data),
    .ISSUE_VALID (p_issue_valid), .ISSUE_RD (p_issue_rd),
    .ISSUE_READY (p_issue_ready), .ANY_PENDING (p_any_pending)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Architectural model of the default instance.
  logic [XLEN-1:0] m_reg [NREGS];
  bit              m_pend [NREGS];
  bit              model_ok = 1'b0;

  always @(posedge clk) begin
    int  rd;
    bit  claim;
    int  a;
    if (reset) begin
      for (int r = 0; r < NREGS; r++) begin
        m_reg[r]  = '0;
        m_pend[r] = 1'b0;
      end
      model_ok = 1'b1;
    end else if (model_ok) begin
      rd    = int'(issue_rd);
      claim = issue_valid && (rd != 0) && !m_pend[rd];
      for (int wp = 0; wp < NWP; wp++) begin
        a = int'(w_addr[wp*AW +: AW]);
        if (w_en[wp] && a != 0) begin
          m_reg[a]  = w_data[wp*XLEN +: XLEN];
          m_pend[a] = 1'b0;
        end
      end
      if (claim) m_pend[rd] = 1'b1;
    end
  end

  // Every-cycle compare of all default-instance outputs against the model.
  always @(negedge clk) begin
    int              a;
    logic [XLEN-1:0] ed;
    bit              ep;
    bit              eany;
    if (model_ok) begin
      for (int p = 0; p < NRP; p++) begin
        a  = int'(r_addr[p*AW +: AW]);
        ed = (a == 0) ? '0 : m_reg[a];
        ep = (a == 0) ? 1'b0 : m_pend[a];
`ifdef REGFILE_BYPASS_EN
        for (int wp = 0; wp < NWP; wp++) begin
          if (a != 0 && w_en[wp] && int'(w_addr[wp*AW +: AW]) == a) begin
            ed = w_data[wp*XLEN +: XLEN];
            ep = 1'b0;
          end
        end
`endif
        chk($sformatf("cyc_rdata%0d", p), r_data[p*XLEN +: XLEN], ed);
        chk($sformatf("cyc_rpend%0d", p), r_pending[p], ep);
      end
      eany = 1'b0;
      for (int r = 0; r < NREGS; r++) eany |= m_pend[r];
      chk("cyc_issue_ready", issue_ready, (issue_rd == '0) ? 1'b1 : !m_pend[int'(issue_rd)]);
      chk("cyc_any_pending", any_pending, eany);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle();
    w_en          = '0;
    issue_valid   = 1'b0;
    p_w_en        = '0;
    p_issue_valid = 1'b0;
  endtask

  task automatic wr(input int wp, input int a, input logic [XLEN-1:0] d);
    w_en[wp]                 = 1'b1;
    w_addr[wp*AW +: AW]      = a[AW-1:0];
    w_data[wp*XLEN +: XLEN]  = d;
  endtask

  task automatic rdp(input int p, input int a);
    r_addr[p*AW +: AW] = a[AW-1:0];
  endtask

  task automatic issue(input int rd);
    issue_valid = 1'b1;
    issue_rd    = rd[AW-1:0];
  endtask

  task automatic p_wr(input int a, input logic [PX-1:0] d);
    p_w_en   = 1'b1;
    p_w_addr = a[PAW-1:0];
    p_w_data = d;
  endtask

  task automatic p_rdp(input int p, input int a);
    p_r_addr[p*PAW +: PAW] = a[PAW-1:0];
  endtask

  function automatic logic [XLEN-1:0] rdata(input int p);
    return r_data[p*XLEN +: XLEN];
  endfunction

  function automatic logic [PX-1:0] p_rdata(input int p);
    return p_r_data[p*PX +: PX];
  endfunction

  // ---------------- directed sequence ----------------
  initial begin
    reset  = 1'b1;
    r_addr = '0; w_addr = '0; w_data = '0; issue_rd = '0;
    p_r_addr = '0; p_w_addr = '0; p_w_data = '0; p_issue_rd = '0;
    idle();
    step_clk();
    step_clk();
    reset = 1'b0;

    // Reset state.
    rdp(0, 5); rdp(1, 8); issue_rd = 5'd6;
    settle();
    chk("rst_rdata", rdata(0), 64'h0);
    chk("rst_rpend", r_pending[0], 1'b0);
    chk("rst_any_pending", any_pending, 1'b0);
    chk("rst_issue_ready", issue_ready, 1'b1);

    // Reduced instance: out-of-range address 30 and independent read ports.
    step_clk(); p_wr(30, 32'h1234); p_rdp(0, 30);
    settle();
    chk("p_oor_same_cycle", p_rdata(0), 32'h0);
    chk("p_oor_same_pend", p_r_pending[0], 1'b0);
    step_clk(); p_wr(1, 32'h11);
    step_clk(); p_wr(2, 32'h22);
    step_clk(); p_wr(6, 32'h66);
    step_clk(); p_wr(23, 32'h2323);
    step_clk(); idle();
    p_rdp(0, 1); p_rdp(1, 2); p_rdp(2, 23);
    exp_q.push_back(64'h11); exp_q.push_back(64'h22); exp_q.push_back(64'h2323);
    settle();
    for (int p = 0; p < PRP; p++) chk($sformatf("p_port%0d", p), p_rdata(p), exp_q.pop_front());
    p_rdp(0, 30); p_rdp(2, 6);
    settle();
    chk("p_oor_dropped", p_rdata(0), 32'h0);
    chk("p_oor_pend", p_r_pending[0], 1'b0);
    chk("p_x6_no_alias", p_rdata(2), 32'h66);
    chk("p_any_pending", p_any_pending, 1'b0);

    // Preload x5, claim x6, then reset mid-operation.
    step_clk(); wr(0, 5, 64'hDEAD); issue(6);
    step_clk(); idle(); rdp(0, 5);
    settle();
    chk("preload_x5", rdata(0), 64'hDEAD);
    chk("preload_any", any_pending, 1'b1);
    step_clk(); reset = 1'b1; wr(0, 5, 64'h1); issue(8);
    step_clk(); reset = 1'b0; idle(); rdp(0, 5); rdp(1, 8); issue_rd = 5'd6;
    settle();
    chk("midrst_x5", rdata(0), 64'h0);
    chk("midrst_x8_pend", r_pending[1], 1'b0);
    chk("midrst_any", any_pending, 1'b0);
    chk("midrst_ready", issue_ready, 1'b1);

    // x0 is immune to writes; preload x4 with a known old value.
    step_clk(); wr(0, 0, 64'hFFFF); wr(1, 4, 64'h77);
    step_clk(); idle(); rdp(0, 0);
    settle();
    chk("x0_data", rdata(0), 64'h0);
    chk("x0_pend", r_pending[0], 1'b0);

    // Two ports hit x7: port 1 wins.
    step_clk(); wr(0, 7, 64'h11); wr(1, 7, 64'h22);
    step_clk(); idle(); rdp(0, 7);
    settle();
    chk("prio_x7", rdata(0), 64'h22);

    // WAW stall on x3.
    step_clk(); issue(3);
    settle();
    chk("x3_ready_before", issue_ready, 1'b1);
    step_clk(); idle(); issue_rd = 5'd3; rdp(0, 3);
    settle();
    chk("x3_pending", r_pending[0], 1'b1);
    chk("x3_ready_stall", issue_ready, 1'b0);
    chk("x3_any", any_pending, 1'b1);
    step_clk(); issue(3);
    step_clk(); idle();
    settle();
    chk("x3_retry_no_effect", r_pending[0], 1'b1);

    // Writeback clears x3; same-cycle view depends on bypass.
    step_clk(); wr(0, 3, 64'h42);
    settle();
`ifdef REGFILE_BYPASS_EN
    chk("x3_wb_cycle_data", rdata(0), 64'h42);
    chk("x3_wb_cycle_pend", r_pending[0], 1'b0);
`else
    chk("x3_wb_cycle_data", rdata(0), 64'h0);
    chk("x3_wb_cycle_pend", r_pending[0], 1'b1);
`endif
    step_clk(); idle();
    settle();
    chk("x3_after_wb", rdata(0), 64'h42);
    chk("x3_cleared", r_pending[0], 1'b0);
    chk("x3_any_clear", any_pending, 1'b0);

    // Claim and writeback of x9 in one cycle: the claim survives.
    step_clk(); issue(9); wr(0, 9, 64'h5);
    settle();
    chk("x9_ready", issue_ready, 1'b1);
    step_clk(); idle(); rdp(0, 9);
    settle();
    chk("x9_data", rdata(0), 64'h5);
    chk("x9_still_pending", r_pending[0], 1'b1);
    step_clk(); wr(1, 9, 64'h6);
    step_clk(); idle();

    // Bypass check on x4 (old value 0x77), two ports writing it.
    step_clk(); issue(4);
    step_clk(); idle(); wr(0, 4, 64'h1111); wr(1, 4, 64'hABCD); rdp(0, 4); rdp(1, 9);
    settle();
`ifdef REGFILE_BYPASS_EN
    chk("byp_x4_data", rdata(0), 64'hABCD);
    chk("byp_x4_pend", r_pending[0], 1'b0);
`else
    chk("byp_x4_data", rdata(0), 64'h77);
    chk("byp_x4_pend", r_pending[0], 1'b1);
`endif
    chk("byp_x9_other_port", rdata(1), 64'h6);
    step_clk(); idle();
    settle();
    chk("x4_after_wb", rdata(0), 64'hABCD);
    chk("x4_cleared", r_pending[0], 1'b0);

    // Mixed traffic on a small address window, checked by the model.
    for (int c = 0; c < 400; c++) begin
      step_clk();
      reset = ($urandom_range(0, 49) == 0);
      for (int wp = 0; wp < NWP; wp++) begin
        w_en[wp] = ($urandom_range(0, 2) == 0);
        w_addr[wp*AW +: AW] = AW'($urandom_range(0, 7));
        w_data[wp*XLEN +: XLEN] = {$urandom, $urandom};
      end
      for (int p = 0; p < NRP; p++) r_addr[p*AW +: AW] = AW'($urandom_range(0, 7));
      issue_valid = ($urandom_range(0, 1) == 1);
      issue_rd    = AW'($urandom_range(0, 7));
    end
    step_clk(); reset = 1'b0; idle();
    step_clk();
    step_clk();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
